// File: rtl/reel_speed_sequencer_pkg.sv
// Shared types and constants for the reel speed sequencer.
package reel_pkg;

  localparam int unsigned SPEED_W        = 20;
  localparam int unsigned DEFAULT_CLK_HZ = 50000000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACCEL = 3'd1,
    SPIN  = 3'd2,
    DECEL = 3'd3,
    HALT  = 3'd4
  } reel_state_t;

  typedef struct packed {
    logic busy;
    logic div_rst_n;
    logic done;
  } reel_out_t;

  // Registered status outputs that belong to each state.
  function automatic reel_out_t state_outputs(input reel_state_t s);
    reel_out_t o;
    o = '0;
    case (s)
      ACCEL, SPIN, DECEL: begin
        o.busy      = 1'b1;
        o.div_rst_n = 1'b1;
      end
      HALT: begin
        o.busy = 1'b1;
        o.done = 1'b1;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/reel_speed_sequencer_if.sv
// Control/status bundle between the game FSM (master) and one reel sequencer (slave).
interface reel_speed_sequencer_if;
  import reel_pkg::*;

  logic               i_start;
  logic               i_stop_req;
  logic [SPEED_W-1:0] o_speed;
  logic               o_div_rst_n;
  logic               o_busy;
  logic               o_done;
  logic [2:0]         o_state;

  modport master (
    output i_start, i_stop_req,
    input  o_speed, o_div_rst_n, o_busy, o_done, o_state
  );

  modport slave (
    input  i_start, i_stop_req,
    output o_speed, o_div_rst_n, o_busy, o_done, o_state
  );

endinterface

// File: rtl/reel_speed_sequencer_tick_gen.sv
// Ramp tick generator: pulses tick every TICK_CYCLES enabled cycles; clr or !en holds it at 0.
module tick_gen #(
  parameter int unsigned TICK_CYCLES = 2500000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned    CW   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0]  LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst || clr || !en) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = en && !clr && (r_cnt == LAST);

endmodule

// File: rtl/reel_speed_sequencer.sv
// Per-reel spin sequencer: ramps the divider speed up, holds, ramps down, pulses done.
// Optional macro REEL_SPIN_TIMEOUT_EN adds an automatic stop after SPIN_TICKS ticks in SPIN.
module reel_speed_sequencer
  import reel_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = 2500000,
  parameter int unsigned MIN_SPEED   = 2,
  parameter int unsigned MAX_SPEED   = 40,
  parameter int unsigned STEP        = 2,
  parameter int unsigned SPIN_TICKS  = 60
) (
  input  logic                  clk,
  input  logic                  rst,
  reel_speed_sequencer_if.slave bus
);

  if (MIN_SPEED < 1 || MAX_SPEED <= MIN_SPEED || MAX_SPEED > 1048575 ||
      STEP < 1 || TICK_CYCLES < 1 || SPIN_TICKS < 1) begin : g_bad_params
    $error("reel_speed_sequencer: illegal parameter set");
  end

  localparam logic [SPEED_W-1:0] MIN_V = SPEED_W'(MIN_SPEED);
  localparam logic [SPEED_W-1:0] MAX_V = SPEED_W'(MAX_SPEED);

  reel_state_t        r_state;
  logic [SPEED_W-1:0] r_speed;
  reel_out_t          r_out;

  logic               w_tick;
  logic               w_en;
  logic               w_stop;
  logic               w_timeout;
  logic               w_clr;
  logic [SPEED_W:0]   w_inc;
  logic [SPEED_W:0]   w_dec;
  logic [SPEED_W-1:0] w_up;
  logic [SPEED_W-1:0] w_down;

  // One extra bit so a ramp step can never wrap past either limit.
  assign w_inc  = {1'b0, r_speed} + (SPEED_W+1)'(STEP);
  assign w_dec  = {1'b0, r_speed} - (SPEED_W+1)'(STEP);
  assign w_up   = (w_inc >= {1'b0, MAX_V}) ? MAX_V : w_inc[SPEED_W-1:0];
  assign w_down = (w_dec[SPEED_W] || (w_dec < {1'b0, MIN_V})) ? MIN_V : w_dec[SPEED_W-1:0];

  assign w_en   = (r_state == ACCEL) || (r_state == SPIN) || (r_state == DECEL);
  assign w_stop = ((r_state == ACCEL) || (r_state == SPIN)) && bus.i_stop_req;
  assign w_clr  = w_stop || w_timeout;

`ifdef REEL_SPIN_TIMEOUT_EN
  localparam logic [15:0] SPIN_LAST = 16'(SPIN_TICKS - 1);

  logic [15:0] r_spin_cnt;

  assign w_timeout = (r_state == SPIN) && w_tick && (r_spin_cnt == SPIN_LAST);

  // Holding at zero outside SPIN gives a cleared count on every SPIN entry.
  always_ff @(posedge clk) begin
    if (!rst || r_state != SPIN) begin
      r_spin_cnt <= '0;
    end else if (w_tick) begin
      r_spin_cnt <= r_spin_cnt + 16'd1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  tick_gen #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_clr),
    .en   (w_en),
    .tick (w_tick)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_speed <= MIN_V;
      r_out   <= state_outputs(IDLE);
    end else begin
      r_out <= state_outputs(r_state);
      case (r_state)
        IDLE: begin
          r_speed <= MIN_V;
          if (bus.i_start) begin
            r_state <= ACCEL;
            r_out   <= state_outputs(ACCEL);
          end
        end
        ACCEL: begin
          // A stop request outranks a coincident tick: no final increment.
          if (w_stop) begin
            r_state <= DECEL;
            r_out   <= state_outputs(DECEL);
          end else if (w_tick) begin
            r_speed <= w_up;
            if (w_up == MAX_V) begin
              r_state <= SPIN;
              r_out   <= state_outputs(SPIN);
            end
          end
        end
        SPIN: begin
          r_speed <= MAX_V;
          if (w_clr) begin
            r_state <= DECEL;
            r_out   <= state_outputs(DECEL);
          end
        end
        DECEL: begin
          if (w_tick) begin
            r_speed <= w_down;
            if (w_down == MIN_V) begin
              r_state <= HALT;
              r_out   <= state_outputs(HALT);
            end
          end
        end
        HALT: begin
          r_state <= IDLE;
          r_speed <= MIN_V;
          r_out   <= state_outputs(IDLE);
        end
        default: begin
          r_state <= IDLE;
          r_speed <= MIN_V;
          r_out   <= state_outputs(IDLE);
        end
      endcase
    end
  end

  assign bus.o_speed     = r_speed;
  assign bus.o_state     = r_state;
  assign bus.o_busy      = r_out.busy;
  assign bus.o_div_rst_n = r_out.div_rst_n;
  assign bus.o_done      = r_out.done;

endmodule

// File: doc/reel_speed_sequencer.md
Name: reel_speed_sequencer

Overview:
- Drives the `speed` input and the active-low reset of one slot-machine reel clock divider.
- Sequences each spin through spin-up, a steady spin, then deceleration to a stop.
- One instance per reel; the top-level game FSM issues `start` and `stop_req` and watches `done`.
- Guarantees the divider never receives speed 0 (its divisor).

Parameters:
- TICK_CYCLES, 2500000: clk cycles per ramp tick (20 Hz at 50 MHz).
- MIN_SPEED, 2: speed at rest and at the end of a ramp; must be ≥1.
- MAX_SPEED, 40: steady spin speed; must be ≤ 2^20-1 and > MIN_SPEED.
- STEP, 2: speed change per tick during ramps; must be ≥1.
- SPIN_TICKS, 60: ticks spent in SPIN before auto-stop (only with the optional feature).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  synchronous, active-low reset.
- start  in  1  level; sampled only in IDLE; begins a spin.
- stop_req  in  1  level; sampled in ACCEL and SPIN; begins deceleration.
- speed  out  20  divider speed value; registered; always in [MIN_SPEED, MAX_SPEED].
- div_rst_n  out  1  divider reset; 0 holds the reel frozen.
- busy  out  1  1 in any state other than IDLE.
- done  out  1  single-cycle pulse when a spin completes.
- state  out  3  current state encoding, for debug LEDs.

Behaviour:
- Reset (rst==0 at posedge), regardless of state:
  - state=IDLE, speed=MIN_SPEED, div_rst_n=0, busy=0, done=0.
  - Tick counter = 0; spin tick counter = 0.
  - Reset mid-spin aborts immediately and produces no done pulse.
- States:
  - IDLE=0: div_rst_n=0, speed=MIN_SPEED. start==1 → ACCEL next cycle. stop_req is ignored.
  - ACCEL=1: div_rst_n=1.
    - On each tick, speed = min(speed+STEP, MAX_SPEED).
    - When speed reaches MAX_SPEED → SPIN on that same edge.
    - stop_req==1 → DECEL next cycle from the current speed; the tick counter is cleared.
  - SPIN=2: speed holds at MAX_SPEED. stop_req==1 → DECEL; the tick counter is cleared.
  - DECEL=3:
    - On each tick, speed = max(speed-STEP, MIN_SPEED). Use saturating subtract: compute with 21 bits, so there is no wrap below MIN_SPEED.
    - When speed reaches MIN_SPEED → HALT.
    - start and stop_req are ignored.
  - HALT=4: lasts one cycle. done=1 this cycle, div_rst_n=0. Next state IDLE.
- Tick generation:
  - Counter runs 0..TICK_CYCLES-1 and asserts tick on the cycle where it equals TICK_CYCLES-1, then wraps to 0.
  - Cleared on entry to ACCEL or DECEL, so the first speed change comes exactly TICK_CYCLES cycles after entry.
  - The counter is held at 0 in IDLE and HALT.
- Latencies:
  - start is sampled at edge N → state=ACCEL, busy=1, div_rst_n=1 after edge N.
  - The first speed increment lands after edge N+TICK_CYCLES.
- Simultaneous events:
  - A tick and stop_req in the same ACCEL cycle: stop_req wins, the speed does not increment, and the state goes to DECEL.
  - start held high through HALT: IDLE is entered, and a new spin begins one cycle later (re-trigger allowed).
- Encodings 5..7 are illegal and recover to IDLE.

Optional Feature:
- Macro: REEL_SPIN_TIMEOUT_EN.
- When defined:
  - A 16-bit spin tick counter increments on each tick in SPIN.
  - When it reaches SPIN_TICKS-1 on a tick, the state goes to DECEL exactly as if stop_req had been asserted.
  - The counter is cleared on entry to SPIN.
- When undefined:
  - SPIN persists until stop_req.
  - The counter and SPIN_TICKS logic are absent; the parameter is accepted but unused.

Decomposition:
- Package reel_pkg:
  - reel_state_t enum (IDLE, ACCEL, SPIN, DECEL, HALT; 3-bit).
  - SPEED_W=20 localparam.
  - DEFAULT_CLK_HZ=50000000.
- Sub-module tick_gen (params TICK_CYCLES; ports clk, rst, clr, en, tick) holds the tick counter. Its counter width is $clog2(TICK_CYCLES).

Test Plan (TICK_CYCLES=4, MIN=2, MAX=10, STEP=3, SPIN_TICKS=5):
- Reset then idle 20 cycles → speed=2, div_rst_n=0, busy=0, done=0 throughout.
- 1-cycle start pulse → speed goes 2→5→8→10 at cycles +4, +8, +12 (saturates at 10, not 11). State=SPIN after the +12 edge.
- stop_req in SPIN → speed goes 10→7→4→2 at 4-cycle spacing. Then one HALT cycle with done=1, then IDLE with div_rst_n=0.
- stop_req on the same cycle as the first ACCEL tick → speed stays 2, then DECEL → HALT at the next tick. Exactly one done pulse.
- rst=0 while in SPIN at speed=10 → next cycle state=IDLE, speed=2, div_rst_n=0, and no done pulse.
- With REEL_SPIN_TIMEOUT_EN defined and no stop_req → DECEL entered 5 ticks (20 cycles) after SPIN entry. Without the macro → SPIN holds for 200 cycles.
